// File: rtl/green_track_pkg.sv
// Shared widths, cleared bounding-box values and FSM encoding for the green
// centroid tracker.
package green_track_pkg;

  localparam int CNT_W   = 19;
  localparam int SUM_W   = 28;
  localparam int COORD_W = 10;

  localparam logic [COORD_W-1:0] BOX_MIN_CLR = '1;
  localparam logic [COORD_W-1:0] BOX_MAX_CLR = '0;
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start edge
// performs the first step, so done is sampled SUM_W edges after start.
module seq_divider
  import green_track_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] dvs_q;
  logic [4:0]       step_q;
  logic             active_q;
  logic             done_q;

  logic [CNT_W-1:0] src_rem;
  logic [SUM_W-1:0] src_quo;
  logic [CNT_W-1:0] src_dvs;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;
  logic             ge;

  // quo_q holds the not-yet-consumed dividend bits above the quotient bits.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[SUM_W-1]};
    diff    = trial - {1'b0, src_dvs};
    ge      = (trial >= {1'b0, src_dvs});
    rem_d   = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    quo_d   = {src_quo[SUM_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvs_q    <= divisor;
        step_q   <= 5'd1;
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        step_q <= step_q + 5'd1;
        if (step_q == 5'(SUM_W - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/green_centroid_tracker.sv
// Per-frame green-pixel statistics (count, sums, bounding box) with a
// sequential centroid divide that overlaps accumulation of the next frame.
module green_centroid_tracker
  import green_track_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic               PCLK,
  input  logic               reset,
  input  logic               hit_valid,
  input  logic               eh_verde,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_end,
  output logic               result_valid,
  output logic               found,
  output logic [COORD_W-1:0] centroid_x,
  output logic [COORD_W-1:0] centroid_y,
  output logic [COORD_W-1:0] box_xmin,
  output logic [COORD_W-1:0] box_xmax,
  output logic [COORD_W-1:0] box_ymin,
  output logic [COORD_W-1:0] box_ymax,
  output logic [CNT_W-1:0]   pix_count,
  output logic               busy,
  output logic               frame_drop
);

  localparam logic [COORD_W:0] H_LIM   = (COORD_W + 1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_LIM   = (COORD_W + 1)'(V_ACTIVE);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  state_e state_q, state_d;

  logic [CNT_W-1:0]   acc_cnt_q, upd_cnt;
  logic [SUM_W-1:0]   acc_sx_q, acc_sy_q, upd_sx, upd_sy;
  logic [COORD_W-1:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
  logic [COORD_W-1:0] upd_xmin, upd_xmax, upd_ymin, upd_ymax;

  logic [CNT_W-1:0]   snap_cnt_q;
  logic [SUM_W-1:0]   snap_sy_q;
  logic [COORD_W-1:0] snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q;
  logic               snap_found_q;
  logic [COORD_W-1:0] cx_q, cy_q;

  logic               hit, snap_take, upd_found;
  logic               div_start, div_done;
  logic [SUM_W-1:0]   div_dividend, div_quot;
  logic [CNT_W-1:0]   div_divisor;

  // Statistics as they stand after this cycle's hit; snapshots use these.
  always_comb begin
    hit       = hit_valid & eh_verde & ({1'b0, x} < H_LIM) & ({1'b0, y} < V_LIM);
    upd_cnt   = (hit && acc_cnt_q != CNT_MAX) ? acc_cnt_q + 1'b1 : acc_cnt_q;
    upd_sx    = hit ? acc_sx_q + {{(SUM_W-COORD_W){1'b0}}, x} : acc_sx_q;
    upd_sy    = hit ? acc_sy_q + {{(SUM_W-COORD_W){1'b0}}, y} : acc_sy_q;
    upd_xmin  = (hit && x < acc_xmin_q) ? x : acc_xmin_q;
    upd_xmax  = (hit && x > acc_xmax_q) ? x : acc_xmax_q;
    upd_ymin  = (hit && y < acc_ymin_q) ? y : acc_ymin_q;
    upd_ymax  = (hit && y > acc_ymax_q) ? y : acc_ymax_q;
    upd_found = (upd_cnt >= MIN_CNT);
  end

  always_comb begin
    state_d      = state_q;
    snap_take    = 1'b0;
    div_start    = 1'b0;
    div_dividend = upd_sx;
    div_divisor  = upd_cnt;
    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          snap_take = 1'b1;
          if (upd_found) begin
            state_d   = DIV_X;
            div_start = 1'b1;
          end else begin
            state_d = PUBLISH;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          state_d      = DIV_Y;
          div_start    = 1'b1;
          div_dividend = snap_sy_q;
          div_divisor  = snap_cnt_q;
        end
      end
      DIV_Y:   if (div_done) state_d = PUBLISH;
      PUBLISH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // A frame boundary always restarts accumulation, even when it is dropped.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      acc_sx_q   <= '0;
      acc_sy_q   <= '0;
      acc_xmin_q <= BOX_MIN_CLR;
      acc_xmax_q <= BOX_MAX_CLR;
      acc_ymin_q <= BOX_MIN_CLR;
      acc_ymax_q <= BOX_MAX_CLR;
    end else if (frame_end) begin
      acc_cnt_q  <= '0;
      acc_sx_q   <= '0;
      acc_sy_q   <= '0;
      acc_xmin_q <= BOX_MIN_CLR;
      acc_xmax_q <= BOX_MAX_CLR;
      acc_ymin_q <= BOX_MIN_CLR;
      acc_ymax_q <= BOX_MAX_CLR;
    end else begin
      acc_cnt_q  <= upd_cnt;
      acc_sx_q   <= upd_sx;
      acc_sy_q   <= upd_sy;
      acc_xmin_q <= upd_xmin;
      acc_xmax_q <= upd_xmax;
      acc_ymin_q <= upd_ymin;
      acc_ymax_q <= upd_ymax;
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      snap_cnt_q   <= '0;
      snap_sy_q    <= '0;
      snap_xmin_q  <= '0;
      snap_xmax_q  <= '0;
      snap_ymin_q  <= '0;
      snap_ymax_q  <= '0;
      snap_found_q <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      if (snap_take) begin
        snap_cnt_q   <= upd_cnt;
        snap_sy_q    <= upd_sy;
        snap_xmin_q  <= upd_xmin;
        snap_xmax_q  <= upd_xmax;
        snap_ymin_q  <= upd_ymin;
        snap_ymax_q  <= upd_ymax;
        snap_found_q <= upd_found;
      end
      if (state_q == DIV_X && div_done) cx_q <= div_quot[COORD_W-1:0];
      if (state_q == DIV_Y && div_done) cy_q <= div_quot[COORD_W-1:0];
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      frame_drop   <= 1'b0;
      found        <= 1'b0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      pix_count    <= '0;
    end else begin
      result_valid <= (state_q == PUBLISH);
      frame_drop   <= frame_end && (state_q != ACCUM);
      if (state_q == PUBLISH) begin
        found      <= snap_found_q;
        pix_count  <= snap_cnt_q;
        centroid_x <= snap_found_q ? cx_q : '0;
        centroid_y <= snap_found_q ? cy_q : '0;
        box_xmin   <= snap_found_q ? snap_xmin_q : '0;
        box_xmax   <= snap_found_q ? snap_xmax_q : '0;
        box_ymin   <= snap_found_q ? snap_ymin_q : '0;
        box_ymax   <= snap_found_q ? snap_ymax_q : '0;
      end
    end
  end

  assign busy = (state_q != ACCUM);

  seq_divider u_div (
    .clk      (PCLK),
    .rst      (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_green_centroid_tracker.sv
// Bench for green_centroid_tracker: table-driven frames, hand sequences for
// drop/coincident-hit/reset, and random frames against a pixel-list model.
module tb_green_centroid_tracker;

  localparam int MIN_PIX = 64;

  logic       PCLK = 1'b0;
  logic       reset;
  logic       hit_valid, eh_verde, frame_end;
  logic [9:0] x, y;
  logic       result_valid, found, busy, frame_drop;
  logic [9:0] centroid_x, centroid_y, box_xmin, box_xmax, box_ymin, box_ymax;
  logic [18:0] pix_count;

  green_centroid_tracker #(.H_ACTIVE(640), .V_ACTIVE(480), .MIN_PIXELS(64)) dut (
    .PCLK(PCLK), .reset(reset), .hit_valid(hit_valid), .eh_verde(eh_verde),
    .x(x), .y(y), .frame_end(frame_end), .result_valid(result_valid),
    .found(found), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin),
    .box_ymax(box_ymax), .pix_count(pix_count), .busy(busy),
    .frame_drop(frame_drop)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int rv_count = 0;
  int busy_until = 0;
  logic [79:0] exp_q[$];
  int exp_cyc_q[$];
  int mx_q[$];
  int my_q[$];

  typedef struct {
    int x0; int y0; int w; int h; int rep; bit bad;
    bit found; int cnt; int cx; int cy; int xmin; int xmax; int ymin; int ymax;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the frame's accepted hits are a plain list; statistics are
  // computed from it when a boundary is accepted.
  task automatic model_frame_end();
    longint sx = 0, sy = 0;
    int cnt, xmn = 1023, xmx = 0, ymn = 1023, ymx = 0;
    logic f;
    logic [18:0] c19;
    logic [9:0] cx, cy, a, b, c, d;
    cnt = mx_q.size();
    foreach (mx_q[i]) begin
      sx += mx_q[i];
      sy += my_q[i];
      if (mx_q[i] < xmn) xmn = mx_q[i];
      if (mx_q[i] > xmx) xmx = mx_q[i];
      if (my_q[i] < ymn) ymn = my_q[i];
      if (my_q[i] > ymx) ymx = my_q[i];
    end
    f   = (cnt >= MIN_PIX);
    c19 = cnt[18:0];
    cx = '0; cy = '0; a = '0; b = '0; c = '0; d = '0;
    if (f) begin
      cx = 10'(sx / cnt); cy = 10'(sy / cnt);
      a = xmn[9:0]; b = xmx[9:0]; c = ymn[9:0]; d = ymx[9:0];
    end
    exp_q.push_back({f, c19, cx, cy, a, b, c, d});
    exp_cyc_q.push_back(cyc + (f ? 57 : 1));
    busy_until = cyc + (f ? 58 : 2);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic hv, input logic g, input int px, input int py,
                      input logic fe);
    logic accepted;
    hit_valid = hv; eh_verde = g; x = px[9:0]; y = py[9:0]; frame_end = fe;
    @(posedge PCLK); #1;
    hit_valid = 1'b0; eh_verde = 1'b0; frame_end = 1'b0;
    if (hv && g && px < 640 && py < 480) begin
      mx_q.push_back(px);
      my_q.push_back(py);
    end
    if (fe) begin
      accepted = (cyc >= busy_until);
      check("frame_drop", frame_drop, !accepted);
      if (accepted) model_frame_end();
      mx_q.delete();
      my_q.delete();
    end
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic send_rect(input vec_t v);
    for (int j = 0; j < v.h; j++)
      for (int i = 0; i < v.w; i++)
        for (int r = 0; r < v.rep; r++)
          step(1'b1, 1'b1, v.x0 + i, v.y0 + j, 1'b0);
    if (v.bad) begin
      step(1'b1, 1'b1, 640, v.y0, 1'b0);
      step(1'b1, 1'b1, v.x0, 480, 1'b0);
      step(1'b1, 1'b0, v.x0, v.y0, 1'b0);
      step(1'b0, 1'b1, v.x0, v.y0, 1'b0);
      step(1'b1, 1'b1, 1023, 1023, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wait_idle();
    send_rect(v);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    wait_idle();
    check($sformatf("vec%0d_found", idx), found, v.found);
    check($sformatf("vec%0d_pix_count", idx), pix_count, v.cnt);
    check($sformatf("vec%0d_centroid_x", idx), centroid_x, v.cx);
    check($sformatf("vec%0d_centroid_y", idx), centroid_y, v.cy);
    check($sformatf("vec%0d_box_xmin", idx), box_xmin, v.xmin);
    check($sformatf("vec%0d_box_xmax", idx), box_xmax, v.xmax);
    check($sformatf("vec%0d_box_ymin", idx), box_ymin, v.ymin);
    check($sformatf("vec%0d_box_ymax", idx), box_ymax, v.ymax);
  endtask

  task automatic rand_pixel(input int bx, input int by, input int w);
    step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
         bx + $urandom_range(0, w), by + $urandom_range(0, w), 1'b0);
  endtask

  // ---------------- result monitor ----------------
  initial begin
    logic [79:0] e;
    int ec;
    forever begin
      @(posedge PCLK); #1;
      if (result_valid === 1'b1) begin
        rv_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_result_valid", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result_cycle", cyc, ec);
          check("m_found", found, e[79]);
          check("m_pix_count", pix_count, e[78:60]);
          check("m_centroid_x", centroid_x, e[59:50]);
          check("m_centroid_y", centroid_y, e[49:40]);
          check("m_box_xmin", box_xmin, e[39:30]);
          check("m_box_xmax", box_xmax, e[29:20]);
          check("m_box_ymin", box_ymin, e[19:10]);
          check("m_box_ymax", box_ymax, e[9:0]);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int rv0, bx, by, w, n, g;
    vecs[0] = '{10, 20, 10, 10, 1, 0, 1, 100, 14, 24, 10, 19, 20, 29};
    vecs[1] = '{100, 200, 9, 7, 1, 0, 0, 63, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 1, 1, 64, 1, 1, 64, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{600, 400, 40, 80, 1, 0, 1, 3200, 619, 439, 600, 639, 400, 479};
    vecs[4] = '{5, 7, 8, 8, 1, 1, 1, 64, 8, 10, 5, 12, 7, 14};

    reset = 1'b1; hit_valid = 1'b0; eh_verde = 1'b0; frame_end = 1'b0;
    x = '0; y = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_result_valid", result_valid, 0);
    check("rst_found", found, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_drop", frame_drop, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_centroid_x", centroid_x, 0);
    check("rst_box_xmin", box_xmin, 0);
    @(negedge PCLK) reset = 1'b0;
    @(posedge PCLK); #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // hit coincident with frame_end belongs to the ending frame only
    wait_idle();
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 50 + i, 50 + j, 1'b0);
    step(1'b1, 1'b1, 51, 60, 1'b1);
    wait_idle();
    check("coinc_pix_count", pix_count, 71);
    check("coinc_box_ymax", box_ymax, 60);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1, 1, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    wait_idle();
    check("after_coinc_pix_count", pix_count, 64);
    check("after_coinc_box_ymax", box_ymax, 1);

    // frame_end while busy is dropped and still restarts accumulation
    send_rect(vecs[0]);
    rv0 = rv_count;
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 200, 200, 1'b0);
    repeat (4) step(1'b0, 1'b0, 0, 0, 1'b0);
    check("drop_busy", busy, 1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("frame_drop_pulse_len", frame_drop, 0);
    wait_idle();
    check("drop_single_result", rv_count - rv0, 1);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 300 + i, 300 + j, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    wait_idle();
    check("post_drop_pix_count", pix_count, 80);
    check("post_drop_box_xmin", box_xmin, 300);

    // reset in the middle of the second division
    send_rect(vecs[4]);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    repeat (35) step(1'b0, 1'b0, 0, 0, 1'b0);
    rv0 = rv_count;
    reset = 1'b1;
    #1;
    check("midrst_pix_count", pix_count, 0);
    check("midrst_box_xmin", box_xmin, 0);
    check("midrst_centroid_x", centroid_x, 0);
    check("midrst_found", found, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete(); exp_cyc_q.delete(); mx_q.delete(); my_q.delete();
    busy_until = 0;
    @(posedge PCLK); @(posedge PCLK); #1;
    reset = 1'b0;
    repeat (70) step(1'b0, 1'b0, 0, 0, 1'b0);
    check("midrst_no_result", rv_count - rv0, 0);
    run_vec(vecs[0], 5);

    // random frames; short gaps make some boundaries land while busy
    for (int it = 0; it < 10; it++) begin
      bx = $urandom_range(0, 620);
      by = $urandom_range(0, 470);
      w  = $urandom_range(1, 40);
      n  = $urandom_range(30, 160);
      for (int k = 0; k < n; k++) rand_pixel(bx, by, w);
      step(($urandom_range(0, 1) == 1), 1'b1, bx, by, 1'b1);
      g = $urandom_range(0, 80);
      for (int k = 0; k < g; k++) rand_pixel(bx, by, w);
    end
    wait_idle();
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0);
    check("pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/green_centroid_tracker.md
# green_centroid_tracker

Downstream of the per-pixel green detector: consumes the per-pixel `eh_verde` hit flag with pixel coordinates and builds per-frame statistics of green pixels: count, coordinate sums and bounding box. At each frame boundary it snapshots the statistics. A sequential divider then computes the blob centroid, which is published with a one-cycle valid pulse for the tracking/overlay logic. Accumulation of the next frame continues while the division runs.

## Interface
Parameters:
- `H_ACTIVE`, 640: active width; pixels with `x >= H_ACTIVE` are ignored.
- `V_ACTIVE`, 480: active height; pixels with `y >= V_ACTIVE` are ignored.
- `MIN_PIXELS`, 64: minimum hit count for `found` = 1.

Ports:
- `PCLK` in 1: pixel clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `hit_valid` in 1: qualifies `eh_verde`/`x`/`y` this cycle. The integrator aligns it with the detector's registered `eh_verde`.
- `eh_verde` in 1: pixel is green.
- `x` in 10: pixel column.
- `y` in 10: pixel row.
- `frame_end` in 1: single-cycle pulse after the last pixel of a frame.
- `result_valid` out 1: one-cycle pulse; all result outputs are updated on the same edge.
- `found` out 1: last frame had `pix_count >= MIN_PIXELS`.
- `centroid_x` out 10, `centroid_y` out 10: floor(sum/count).
- `box_xmin`, `box_xmax`, `box_ymin`, `box_ymax` out 10 each: bounding box of hits.
- `pix_count` out 19: hit count of last frame. Saturates at 2^19−1; it cannot be reached at 640×480.
- `busy` out 1: divider/publish in progress.
- `frame_drop` out 1: one-cycle pulse when a `frame_end` is discarded.

## Operation
- Accumulators: `acc_cnt` (19b), `acc_sx` (28b), `acc_sy` (28b), `acc_xmin/xmax/ymin/ymax` (10b).
  - Cleared state: count 0, sums 0, `xmin`=`ymin`=1023, `xmax`=`ymax`=0.
- Hit = `hit_valid & eh_verde & x<H_ACTIVE & y<V_ACTIVE`.
  - On a hit, the count increments, `x`/`y` are added to the sums and the min/max registers are updated.
- FSM `ACCUM` → `DIV_X` → `DIV_Y` → `PUBLISH` → `ACCUM`. Accumulation runs in every state.
- `frame_end` in `ACCUM`:
  - Snapshot the accumulators, including a hit in the same cycle.
  - Clear the accumulators.
  - If snapshot count ≥ `MIN_PIXELS`, go to `DIV_X`; otherwise go to `PUBLISH` with `found`=0.
- `frame_end` while `busy`:
  - Snapshot is not taken and the accumulators are still cleared.
  - `frame_drop` pulses; the FSM is unaffected.
- `DIV_X`: start divider with `sx/cnt`; on `done`, latch the quotient and go to `DIV_Y`. `DIV_Y` is the same with `sy/cnt`.
- `PUBLISH`: register all outputs, pulse `result_valid`, return to `ACCUM`.
  - When `found`=0: centroid and box outputs = 0, `pix_count` = snapshot count.
- Divider: unsigned restoring, 28-bit dividend, 19-bit divisor, one quotient bit per cycle, floor result.
  - Quotient is always < 1024 by construction; the low 10 bits are used.
- Reset (asynchronous, any state):
  - FSM to `ACCUM`, accumulators cleared, division aborted.
  - Outputs: `result_valid`=`found`=`busy`=`frame_drop`=0, centroid/box/`pix_count`=0.

## Timing
- Hits are accumulated on the edge where they are sampled; no input pipeline.
- `frame_end` sampled at edge N, found path:
  - `DIV_X` occupies edges N+1..N+28 and `DIV_Y` occupies N+29..N+56.
  - `PUBLISH` at edge N+57; `result_valid` is high for the cycle following edge N+57.
- `frame_end` sampled at edge N, not-found path: `PUBLISH` at N+1, `result_valid` after edge N+1.
- `busy` = 1 from edge N to edge N+57 (found path) or N+1 (not-found path). A `frame_end` one cycle after `result_valid` is accepted.
- Outputs hold their values between `result_valid` pulses.

## Structure
- Package `green_track_pkg`:
  - FSM state enum.
  - Width constants: `CNT_W`=19, `SUM_W`=28, `COORD_W`=10.
  - Cleared-box constants.
- Sub-module `seq_divider`: `start`, `dividend[SUM_W]`, `divisor[CNT_W]`, `quotient[SUM_W]`, `done`; fixed 28-cycle latency, asynchronous reset.

## Test plan
- 100 hits at (10..19)×(20..29), then `frame_end`:
  - `found`=1, `pix_count`=100, centroid (14,24), box (10,19,20,29).
  - `result_valid` exactly 58 edges after `frame_end`.
- 63 hits, then `frame_end`: `found`=0, `pix_count`=63, centroid/box = 0, `result_valid` 2 edges after.
- Hits at `x`=640 or `y`=480 plus 64 hits at (0,0): `pix_count`=64, centroid (0,0), box all 0.
- Second `frame_end` 10 cycles after the first:
  - `frame_drop` pulses and only one `result_valid` occurs.
  - The following frame's statistics exclude hits from before the dropped boundary.
- Hit coincident with `frame_end`: included in the ending frame (`pix_count` +1), absent from the next frame.
- `reset` asserted mid-`DIV_Y`: outputs immediately 0, no `result_valid`; the next frame completes correctly.
